// File: rtl/moore_seq_pkg.sv
// Shared types and helpers for the programmable Moore sequence detector.
package moore_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_HUNT  = 2'b01,
    S_MATCH = 2'b10
  } state_t;

  // Width needed to hold any length from 0 to max_len inclusive.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; holds at all ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/moore_seq_detect.sv
// Runtime-programmable Moore serial sequence detector with overlap control
// and a saturating match counter; out is decoded from the state register.
module moore_seq_detect
  import moore_seq_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cnt_clear, cnt_inc;

  logic [MAX_LEN-1:0] h;
  logic [LEN_W-1:0]   f;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               len_legal;

  // NOTE: every combinational output gets a default first, so no path
  // through the case/if tree can leave a signal unassigned and infer a latch.
  always_comb begin
    h    = {hist_q[MAX_LEN-2:0], in};
    f    = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit       = (f >= len_q) && (((h ^ pat_q) & mask) == '0);
    len_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_err_d = cfg_err_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;

    if (cfg_load) begin
      // A coincident serial bit is dropped: configuration always wins.
      cnt_clear = 1'b1;
      if (len_legal) begin
        pat_d     = pattern;
        len_d     = pat_len;
        ovl_d     = overlap;
        hist_d    = '0;
        fill_d    = '0;
        cfg_err_d = 1'b0;
        state_d   = S_HUNT;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = S_IDLE;
      end
    end else if (in_valid) begin
      case (state_q)
        S_HUNT, S_MATCH: begin
          hist_d = h;
          if (hit) begin
            state_d = S_MATCH;
            cnt_inc = 1'b1;
            fill_d  = ovl_q ? f : '0;
          end else begin
            state_d = S_HUNT;
            fill_d  = f;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: reset is synchronous and active-high, sampled only on the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (match_count)
  );

  assign out     = (state_q == S_MATCH);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_moore_seq_detect.sv
// Directed self-checking bench for moore_seq_detect; a second instance with a
// 2-bit counter shares the stimulus and is checked only for saturation.
module tb_moore_seq_detect;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               out, out2;
  logic [7:0]         match_count;
  logic [1:0]         match_count2;
  logic               cfg_err, cfg_err2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  moore_seq_detect #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
    .out(out), .match_count(match_count), .cfg_err(cfg_err)
  );

  moore_seq_detect #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
    .out(out2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic cycle(input logic b, input logic v, input logic ld, input logic rst);
    in       = b;
    in_valid = v;
    cfg_load = ld;
    reset    = rst;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    cycle(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    pattern = p;
    pat_len = l;
    overlap = o;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_oc(input string tag, input logic eo, input logic [7:0] ec);
    check({tag, ".out"}, 32'(out), 32'(eo));
    check({tag, ".cnt"}, 32'(match_count), 32'(ec));
  endtask

  initial begin
    in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; reset = 1'b1;
    pattern = '0; pat_len = '0; overlap = 1'b0;

    // Reset state, and serial bits ignored while unconfigured.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_oc("rst", 1'b0, 8'd0);
    check("rst.cfg_err", 32'(cfg_err), 32'd0);
    bit_in(1'b1);
    check_oc("idle_ignore", 1'b0, 8'd0);

    // "101" overlapping: matches after bits 3 and 5.
    load(8'b101, 4'd3, 1'b1);
    check_oc("ovl.load", 1'b0, 8'd0);
    bit_in(1'b1); check_oc("ovl.b1", 1'b0, 8'd0);
    bit_in(1'b0); check_oc("ovl.b2", 1'b0, 8'd0);
    bit_in(1'b1); check_oc("ovl.b3", 1'b1, 8'd1);
    bit_in(1'b0); check_oc("ovl.b4", 1'b0, 8'd1);
    bit_in(1'b1); check_oc("ovl.b5", 1'b1, 8'd2);

    // "101" non-overlapping: only the first match counts; reload clears count.
    load(8'b101, 4'd3, 1'b0);
    check_oc("novl.load", 1'b0, 8'd0);
    bit_in(1'b1); bit_in(1'b0);
    bit_in(1'b1); check_oc("novl.b3", 1'b1, 8'd1);
    bit_in(1'b0); check_oc("novl.b4", 1'b0, 8'd1);
    bit_in(1'b1); check_oc("novl.b5", 1'b0, 8'd1);

    // 8'hA5 full-length pattern with a 2-cycle valid gap mid-stream.
    load(8'hA5, 4'd8, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
    gap(2);
    check_oc("a5.gap", 1'b0, 8'd0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
    check_oc("a5.b7", 1'b0, 8'd0);
    bit_in(1'b1); check_oc("a5.b8", 1'b1, 8'd1);
    gap(3);
    check_oc("a5.hold", 1'b1, 8'd1);

    // Illegal lengths 0 and 9: error flag, idle, bits ignored.
    load(8'hFF, 4'd0, 1'b1);
    check("len0.cfg_err", 32'(cfg_err), 32'd1);
    check_oc("len0", 1'b0, 8'd0);
    load(8'hFF, 4'd9, 1'b1);
    check("len9.cfg_err", 32'(cfg_err), 32'd1);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    check_oc("len9.ignore", 1'b0, 8'd0);
    load(8'b101, 4'd3, 1'b1);
    check("legal.cfg_err", 32'(cfg_err), 32'd0);

    // Length-1 pattern "1": every bit matches; 2-bit counter saturates at 3.
    load(8'h01, 4'd1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      bit_in(1'b1);
      check_oc($sformatf("sat.b%0d", i), 1'b1, 8'(i));
      check($sformatf("sat2.cnt%0d", i), 32'(match_count2), (i > 3) ? 32'd3 : 32'(i));
      check($sformatf("sat2.out%0d", i), 32'(out2), 32'd1);
    end

    // Reset mid-pattern loses config and history.
    load(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_oc("midrst", 1'b0, 8'd0);
    check("midrst.cfg_err", 32'(cfg_err), 32'd0);
    load(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); check_oc("reload.b1", 1'b0, 8'd0);
    bit_in(1'b1); check_oc("reload.b2", 1'b0, 8'd0);
    bit_in(1'b0); check_oc("reload.b3", 1'b0, 8'd0);
    bit_in(1'b1); check_oc("reload.b4", 1'b1, 8'd1);

    // cfg_load coincident with the completing bit discards that bit.
    load(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_oc("coinc", 1'b0, 8'd0);
    bit_in(1'b1); check_oc("coinc.next", 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/moore_seq_detect.md
# moore_seq_detect

Parametrised, runtime-programmable Moore serial sequence detector, the generalisation of the fixed 3-bit "101" detector. It samples a qualified serial bit stream and asserts a registered, state-decoded match flag after a programmed pattern of 1..MAX_LEN bits. It supports overlapping or non-overlapping detection and keeps a saturating match counter. It sits between a serial front end and a status/interrupt block.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, match counter width
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; not overridden)

- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in  in  1  serial data bit
- in_valid  in  1  `in` is sampled on this edge when high
- cfg_load  in  1  one-cycle strobe; latches pattern/pat_len/overlap
- pattern  in  MAX_LEN  pattern; bit pat_len-1 is received first, bit 0 last
- pat_len  in  LEN_W  pattern length; legal 1..MAX_LEN
- overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after a match
- out  out  1  Moore match flag; high iff state == S_MATCH
- match_count  out  CNT_W  saturating count of completed matches
- cfg_err  out  1  last cfg_load carried an illegal pat_len

## Operation
- States (package enum): S_IDLE (unconfigured), S_HUNT, S_MATCH.
- Internal registers:
  - pat_q, len_q, ovl_q: latched configuration.
  - hist[MAX_LEN-1:0]: new bit shifted in at LSB.
  - fill[LEN_W-1:0]: valid history bits, saturating at MAX_LEN.
- Reset:
  - state = S_IDLE.
  - out = 0, match_count = 0, cfg_err = 0.
  - hist = 0, fill = 0, configuration registers = 0.
- cfg_load (any state) has priority over in_valid on the same edge; that bit is discarded.
  - Legal pat_len: latch configuration, clear hist/fill/match_count, cfg_err = 0, go to S_HUNT.
  - pat_len = 0 or > MAX_LEN: go to S_IDLE, cfg_err = 1, counter cleared.
- In S_IDLE, in_valid is ignored.
- Valid bit in S_HUNT or S_MATCH:
  - h = {hist[MAX_LEN-2:0], in}; f = min(fill+1, MAX_LEN).
  - hit = (f ≥ len_q) and (h[len_q-1:0] == pat_q[len_q-1:0]).
  - On hit:
    - Next state S_MATCH.
    - match_count increments unless all ones.
    - If ovl_q = 1: hist = h, fill = f. If ovl_q = 0: fill = 0, hist = h (don't-care).
  - On no hit: next state S_HUNT, hist = h, fill = f.
- No valid bit: state, hist and fill hold. out therefore stays high through in_valid gaps while in S_MATCH (Moore behaviour).
- Back-to-back hits (e.g. pattern "11" overlapping on "111") keep the state in S_MATCH; each hit counts.

## Timing
- out rises one clock after the edge that samples the completing bit. It is decoded from the state register only, with no combinational path from `in`.
- match_count updates on the same edge the state enters or stays in S_MATCH, so it is visible simultaneously with out.
- cfg_err is registered and visible the cycle after cfg_load.
- Reset asserted mid-stream: all outputs are 0 on the next edge and configuration is lost. Reconfiguration is required (S_IDLE).
- Throughput is one bit per clock with no stall.

## Structure
- Package moore_seq_pkg holds:
  - state_t enum {S_IDLE=2'b00, S_HUNT=2'b01, S_MATCH=2'b10}
  - localparam for state width
  - a function computing LEN_W from MAX_LEN
- Sub-module sat_counter (parameter W; inputs clear, inc; output count) is used for match_count.
- Everything else lives in moore_seq_detect: separate next-state/register processes, and out decoded from state.

## Test plan
- Config 3'b101, len 3, overlap=1; stream 1,0,1,0,1 on consecutive valid cycles -> out high the cycle after bits 3 and 5, low after bit 4; match_count = 2.
- Same stream with overlap=0 -> one pulse after bit 3, none after bit 5; match_count = 1.
- Config 8'hA5, len 8; bits 1,0,1,0,0,1,0,1 with in_valid low for 2 cycles between bits 4 and 5 -> out high only after bit 8; out held high during a subsequent 3-cycle in_valid gap.
- cfg_load with pat_len = 0, then pat_len = 9 (MAX_LEN=8) -> cfg_err = 1, state S_IDLE, valid bits ignored, out = 0; a legal cfg_load then clears cfg_err.
- CNT_W=2, pattern "1", len 1, overlap=1; six consecutive valid 1s -> out constantly high after the first bit; match_count saturates at 3.
- Reset asserted after 2 of 3 pattern bits, then cfg_load reapplied and remaining bit sent -> no match; full pattern then needed; cfg_load coincident with a valid completing bit -> bit discarded, no match.
